// File: rtl/led_pattern_gen.sv
// led_pattern_gen: status LED driver for LED1/LED2.
// A prescaler produces a pattern tick, a 3-bit phase counter steps the
// selected pattern, and per-LED stretchers invert an LED for a few ticks
// after each event strobe. All outputs are registered.
module led_pattern_gen #(
    parameter int unsigned TICK_DIV      = 2500000,
    parameter int unsigned STRETCH_TICKS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MODE,
    input  logic       EVT1,
    input  logic       EVT2,
    output logic       LED1,
    output logic       LED2,
    output logic       TICK
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    // Keep the stretch counters at least one bit wide when events are disabled.
    localparam int unsigned SW = (STRETCH_TICKS == 0) ? 1 : $clog2(STRETCH_TICKS + 1);
    localparam logic [CW-1:0] PRE_LAST     = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);
    localparam bit            EVT_EN       = (STRETCH_TICKS != 0);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ALT   = 2'd3
    } mode_t;

    logic [CW-1:0] prescaler;
    logic [2:0]    phase;
    mode_t         mode_q;
    mode_t         mode_in;
    logic          mode_chg;
    logic          tick;
    logic [SW-1:0] stretch1;
    logic [SW-1:0] stretch2;
    logic          base1;
    logic          base2;

    // Tick and mode-change detection from current state and input.
    always_comb begin
        mode_in  = mode_t'(MODE);
        mode_chg = (mode_in != mode_q);
        tick     = (prescaler == PRE_LAST);
    end

    // Prescaler, phase counter and mode register; a mode change restarts the pattern.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler <= '0;
            phase     <= '0;
            mode_q    <= MODE_OFF;
        end else begin
            mode_q <= mode_in;
            if (mode_chg) begin
                prescaler <= '0;
                phase     <= '0;
            end else if (tick) begin
                prescaler <= '0;
                phase     <= phase + 3'd1;
            end else begin
                prescaler <= prescaler + CW'(1);
            end
        end
    end

    // Per-LED stretchers: an event (re)loads, otherwise a tick counts down.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stretch1 <= '0;
            stretch2 <= '0;
        end else begin
            if (EVT_EN && EVT1) begin
                stretch1 <= STRETCH_LOAD;
            end else if (tick && (stretch1 != '0)) begin
                stretch1 <= stretch1 - SW'(1);
            end
            if (EVT_EN && EVT2) begin
                stretch2 <= STRETCH_LOAD;
            end else if (tick && (stretch2 != '0)) begin
                stretch2 <= stretch2 - SW'(1);
            end
        end
    end

    // Base pattern selected by the registered mode and the phase MSB.
    always_comb begin
        base1 = 1'b0;
        base2 = 1'b0;
        unique case (mode_q)
            MODE_OFF: begin
                base1 = 1'b0;
                base2 = 1'b0;
            end
            MODE_ON: begin
                base1 = 1'b1;
                base2 = 1'b1;
            end
            MODE_BLINK: begin
                base1 = phase[2];
                base2 = phase[2];
            end
            MODE_ALT: begin
                base1 = phase[2];
                base2 = ~phase[2];
            end
        endcase
    end

    // Registered outputs: base pattern inverted while a stretch is active.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LED1 <= 1'b0;
            LED2 <= 1'b0;
            TICK <= 1'b0;
        end else begin
            LED1 <= base1 ^ (stretch1 != '0);
            LED2 <= base2 ^ (stretch2 != '0);
            TICK <= tick;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed bench for led_pattern_gen with a
// cycle-counting behavioural model and hand-computed checkpoints.
module tb_led_pattern_gen;

    localparam int unsigned DIV = 4;
    localparam int unsigned ST  = 2;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       evt1;
    logic       evt2;
    logic       led1;
    logic       led2;
    logic       tick;

    logic       evt01;
    logic       evt02;
    logic       led01;
    logic       led02;
    logic       tick0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    led_pattern_gen #(.TICK_DIV(DIV), .STRETCH_TICKS(ST)) dut (
        .CLK (clk),
        .RST (rst),
        .MODE(mode),
        .EVT1(evt1),
        .EVT2(evt2),
        .LED1(led1),
        .LED2(led2),
        .TICK(tick)
    );

    led_pattern_gen #(.TICK_DIV(DIV), .STRETCH_TICKS(0)) dut0 (
        .CLK (clk),
        .RST (rst),
        .MODE(2'd1),
        .EVT1(evt01),
        .EVT2(evt02),
        .LED1(led01),
        .LED2(led02),
        .TICK(tick0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k = clock edges since the pattern last restarted; tick and phase follow from it.
    int unsigned k;
    logic [1:0]  m_mode;
    bit          arm1, arm2;
    int unsigned since1, since2;
    logic [1:0]  exp_leds;
    logic        exp_tick;
    bit          mvalid = 1'b0;

    function automatic bit tick_at(input int unsigned kk);
        return (kk % DIV) == (DIV - 1);
    endfunction

    function automatic logic [1:0] pattern(input logic [1:0] md, input int unsigned kk);
        int unsigned ph;
        bit hi;
        ph = (kk / DIV) % 8;
        hi = (ph >= 4);
        case (md)
            2'd0:    return 2'b00;
            2'd1:    return 2'b11;
            2'd2:    return {hi, hi};
            default: return {hi, !hi};
        endcase
    endfunction

    function automatic bit active(input bit arm, input int unsigned since);
        return arm && (since < ST);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k        <= 0;
            m_mode   <= 2'd0;
            arm1     <= 1'b0;
            arm2     <= 1'b0;
            since1   <= 0;
            since2   <= 0;
            exp_leds <= 2'b00;
            exp_tick <= 1'b0;
            mvalid   <= 1'b1;
        end else begin
            exp_tick <= tick_at(k);
            exp_leds <= pattern(m_mode, k) ^ {active(arm1, since1), active(arm2, since2)};
            k        <= (mode != m_mode) ? 0 : k + 1;
            m_mode   <= mode;
            if (evt1 && ST > 0) begin
                arm1   <= 1'b1;
                since1 <= 0;
            end else if (tick_at(k) && active(arm1, since1)) begin
                since1 <= since1 + 1;
            end
            if (evt2 && ST > 0) begin
                arm2   <= 1'b1;
                since2 <= 0;
            end else if (tick_at(k) && active(arm2, since2)) begin
                since2 <= since2 + 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_leds", {led1, led2}, exp_leds);
            chk("model_tick", {1'b0, tick}, {1'b0, exp_tick});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit found;
        int unsigned pulses;

        rst   = 1'b1;
        mode  = 2'd1;
        evt1  = 1'b1;
        evt2  = 1'b0;
        evt01 = 1'b0;
        evt02 = 1'b0;

        // Reset held three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_leds", {led1, led2}, 2'b00);
            chk("rst_tick", {1'b0, tick}, 2'b00);
        end
        rst  = 1'b0;
        evt1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) chk("rel_c1_leds", {led1, led2}, 2'b00);
            if (i == 2) chk("rel_c2_leds", {led1, led2}, 2'b11);
            if (i == 4) chk("rel_tick_c4", {1'b0, tick}, 2'b00);
            if (i == 5) chk("rel_tick_c5", {1'b0, tick}, 2'b01);
            if (i == 9) chk("rel_tick_c9", {1'b0, tick}, 2'b01);
        end

        // BLINK from a fresh mode change.
        mode = 2'd0;
        repeat (10) @(negedge clk);
        mode = 2'd2;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i == 2 || i == 17) chk("blink_off", {led1, led2}, 2'b00);
            if (i == 18 || i == 33) chk("blink_on", {led1, led2}, 2'b11);
            if (i == 34) chk("blink_off2", {led1, led2}, 2'b00);
            if (i == 9) chk("blink_tick", {1'b0, tick}, 2'b01);
        end

        // ALT, then switch to BLINK mid-period.
        mode = 2'd3;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i >= 2) chk("alt_compl", {1'b0, led1 ^ led2}, 2'b01);
            if (i == 2 || i == 34) chk("alt_01", {led1, led2}, 2'b01);
            if (i == 18) chk("alt_10", {led1, led2}, 2'b10);
        end
        mode = 2'd2;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 2 || i == 17) chk("restart_off", {led1, led2}, 2'b00);
            if (i == 18) chk("restart_on", {led1, led2}, 2'b11);
        end

        // Event stretch with EVT1 coincident with the internal tick.
        mode = 2'd0;
        repeat (4) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (tick) found = 1'b1;
        end
        chk("tick_wait", {1'b0, found}, 2'b01);
        repeat (3) @(negedge clk);
        evt1 = 1'b1;
        @(negedge clk);
        evt1 = 1'b0;
        chk("evt_c1", {led1, led2}, 2'b00);
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2 || i == 9) chk("evt_hold", {led1, led2}, 2'b10);
            if (i == 5) chk("evt_led2", {1'b0, led2}, 2'b00);
            if (i == 10) chk("evt_end", {led1, led2}, 2'b00);
        end

        // Retrigger on LED2 under ON.
        mode = 2'd1;
        repeat (6) @(negedge clk);
        evt2 = 1'b1;
        @(negedge clk);
        evt2 = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            if (i == 5) evt2 = 1'b1;
            if (i == 6) evt2 = 1'b0;
            if (i <= 11) chk("retrig_low", {1'b0, led2}, 2'b00);
            if (i == 8) chk("retrig_led1", {1'b0, led1}, 2'b01);
            if (i == 16) chk("retrig_back", {1'b0, led2}, 2'b01);
        end

        // Simultaneous events.
        repeat (4) @(negedge clk);
        evt1 = 1'b1;
        evt2 = 1'b1;
        @(negedge clk);
        evt1 = 1'b0;
        evt2 = 1'b0;
        chk("simul_c1", {led1, led2}, 2'b11);
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            chk("simul_same", {1'b0, led1 ^ led2}, 2'b00);
            if (i <= 6) chk("simul_low", {led1, led2}, 2'b00);
            if (i == 12) chk("simul_back", {led1, led2}, 2'b11);
        end

        // Disabled events on the STRETCH_TICKS=0 instance.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            evt01 = ~evt01;
            evt02 = ~evt02;
            @(negedge clk);
            chk("dis_leds", {led01, led02}, 2'b11);
            if (tick0) pulses++;
        end
        evt01 = 1'b0;
        evt02 = 1'b0;
        chk("dis_ticks", pulses[1:0] ^ 2'b00, 2'(5 % 4));
        n_cmp++;
        if (pulses != 5) begin
            n_bad++;
            $display("FAIL dis_tick_count: got %0d expected 5", pulses);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
